// File: rtl/free_list_pkg.sv
// Shared rename-stage sizing and the free-list pointer type.
package RR_pkg;

    localparam int unsigned P_REGISTERS = 64;
    localparam int unsigned L_REGISTERS = 32;
    localparam int unsigned INSTR_COUNT = 2;

    localparam int unsigned PREG_W    = $clog2(P_REGISTERS);
    localparam int unsigned PTR_W     = PREG_W + 1;
    localparam int unsigned FREE_INIT = P_REGISTERS - L_REGISTERS;

    // Pointer MSB is the wrap bit; low PREG_W bits index the buffer.
    typedef logic [PTR_W-1:0]  fl_ptr_t;
    typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/fl_ckpt_table.sv
// Checkpoint table of head pointers: one write port, one asynchronous read port.
module fl_ckpt_table #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 7
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] tbl_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (we_i) begin
            tbl_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = tbl_q[raddr_i];

endmodule

// File: rtl/free_list.sv
// Physical-register free list: circular buffer with all-or-nothing multi-slot
// allocation, in-order release, and head-pointer checkpoint/recovery.
module free_list
    import RR_pkg::*;
#(
    parameter int unsigned CKPT_NUM = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [INSTR_COUNT-1:0]              alloc_req,
    output logic [INSTR_COUNT-1:0][PREG_W-1:0]  alloc_preg,
    output logic                                alloc_ok,
    input  logic [INSTR_COUNT-1:0]              rel_en,
    input  logic [INSTR_COUNT-1:0][PREG_W-1:0]  rel_preg,
    input  logic                                ckpt_take,
    input  logic [$clog2(CKPT_NUM)-1:0]         ckpt_id,
    input  logic                                rec_en,
    input  logic [$clog2(CKPT_NUM)-1:0]         rec_ckpt_id,
    output logic [PTR_W-1:0]                    free_count,
    output logic                                empty,
    output logic                                overflow_err
);

    localparam logic [PTR_W:0] OVF_LIMIT = (PTR_W+1)'(FREE_INIT);

    preg_t   buf_q [P_REGISTERS];
    fl_ptr_t head_q, head_d;
    fl_ptr_t tail_q, tail_d;
    logic    ovf_q, ovf_d;

    fl_ptr_t        alloc_n;
    fl_ptr_t        rel_n;
    preg_t          rel_slot [INSTR_COUNT];
    logic           grant;
    logic [PTR_W:0] ovf_sum;
    fl_ptr_t        ckpt_rdata;
    logic           ckpt_we;

    assign free_count   = tail_q - head_q;
    assign empty        = (free_count == '0);
    assign overflow_err = ovf_q;

    // Each requesting slot takes the entry after those taken by lower slots.
    always_comb begin
        alloc_n = '0;
        for (int unsigned s = 0; s < INSTR_COUNT; s++) begin
            alloc_preg[s] = buf_q[preg_t'(head_q + alloc_n)];
            if (alloc_req[s]) begin
                alloc_n = alloc_n + fl_ptr_t'(1);
            end
        end
        grant    = !rec_en && (alloc_n <= free_count);
        alloc_ok = (alloc_n == '0) || grant;
    end

    always_comb begin
        rel_n = '0;
        for (int unsigned s = 0; s < INSTR_COUNT; s++) begin
            rel_slot[s] = preg_t'(tail_q + rel_n);
            if (rel_en[s]) begin
                rel_n = rel_n + fl_ptr_t'(1);
            end
        end
        tail_d  = tail_q + rel_n;
        ovf_sum = {1'b0, free_count} + {1'b0, rel_n};
        ovf_d   = ovf_q || (ovf_sum > OVF_LIMIT);
    end

    // Recovery overrides allocation; the snapshot stores the post-grant head.
    always_comb begin
        head_d = head_q;
        if (rec_en) begin
            head_d = ckpt_rdata;
        end else if (grant) begin
            head_d = head_q + alloc_n;
        end
        ckpt_we = ckpt_take && !rec_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= fl_ptr_t'(FREE_INIT);
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < P_REGISTERS; i++) begin
                buf_q[i] <= (i < FREE_INIT) ? preg_t'(L_REGISTERS + i) : '0;
            end
        end else begin
            for (int unsigned s = 0; s < INSTR_COUNT; s++) begin
                if (rel_en[s]) begin
                    buf_q[rel_slot[s]] <= rel_preg[s];
                end
            end
        end
    end

    fl_ckpt_table #(
        .DEPTH (CKPT_NUM),
        .WIDTH (PTR_W)
    ) u_ckpt_table (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (ckpt_we),
        .waddr_i (ckpt_id),
        .wdata_i (head_d),
        .raddr_i (rec_ckpt_id),
        .rdata_o (ckpt_rdata)
    );

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: queue-level reference model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_free_list;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      alloc_req;
    logic [1:0][5:0] alloc_preg;
    logic            alloc_ok;
    logic [1:0]      rel_en;
    logic [1:0][5:0] rel_preg;
    logic            ckpt_take;
    logic [2:0]      ckpt_id;
    logic            rec_en;
    logic [2:0]      rec_ckpt_id;
    logic [6:0]      free_count;
    logic            empty;
    logic            overflow_err;

    always #5 clk = ~clk;

    free_list #(.CKPT_NUM(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_preg   (alloc_preg),
        .alloc_ok     (alloc_ok),
        .rel_en       (rel_en),
        .rel_preg     (rel_preg),
        .ckpt_take    (ckpt_take),
        .ckpt_id      (ckpt_id),
        .rec_en       (rec_en),
        .rec_ckpt_id  (rec_ckpt_id),
        .free_count   (free_count),
        .empty        (empty),
        .overflow_err (overflow_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: unbounded integer head/tail into a 64-entry ring.
    int m_head;
    int m_tail;
    int m_mem [64];
    int m_ckpt [8];
    bit m_ovf;
    int busy [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_head = 0;
        m_tail = 32;
        for (int i = 0; i < 64; i++) m_mem[i] = (i < 32) ? 32 + i : 0;
        for (int i = 0; i < 8; i++) m_ckpt[i] = 0;
        m_ovf = 1'b0;
        busy.delete();
    endtask

    always @(negedge clk) begin : cmp
        int n, fc, k, m;
        bit exp_ok, grant;
        if (rst) begin
            model_reset();
        end else begin
            n      = $countones(alloc_req);
            fc     = m_tail - m_head;
            exp_ok = (n == 0) || (!rec_en && n <= fc);
            grant  = exp_ok && !rec_en;
            chk("alloc_ok", 32'(alloc_ok), 32'(exp_ok));
            chk("free_count", 32'(free_count), 32'(fc & 127));
            chk("empty", 32'(empty), 32'(fc == 0));
            chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
            k = 0;
            for (int s = 0; s < 2; s++) begin
                if (alloc_req[s]) begin
                    if (grant) begin
                        chk("alloc_preg", 32'(alloc_preg[s]), 32'(m_mem[(m_head + k) % 64]));
                        busy.push_back(m_mem[(m_head + k) % 64]);
                    end
                    k++;
                end
            end
            m = 0;
            for (int s = 0; s < 2; s++) begin
                if (rel_en[s]) begin
                    m_mem[(m_tail + m) % 64] = int'(rel_preg[s]);
                    m++;
                end
            end
            if (fc + m > 32) m_ovf = 1'b1;
            m_tail += m;
            if (rec_en) begin
                m_head = m_ckpt[rec_ckpt_id];
            end else begin
                if (grant) m_head += n;
                if (ckpt_take) m_ckpt[ckpt_id] = m_head;
            end
        end
    end

    task automatic idle();
        alloc_req   = '0;
        rel_en      = '0;
        rel_preg    = '0;
        ckpt_take   = 1'b0;
        ckpt_id     = '0;
        rec_en      = 1'b0;
        rec_ckpt_id = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : drv
        logic [1:0] r;
        int bits [64];
        int bad;
        rst = 1'b1;
        idle();
        repeat (2) cyc();
        rst = 1'b0;
        #3;
        chk("rst_free_count", 32'(free_count), 32);
        chk("rst_empty", 32'(empty), 0);
        chk("rst_ovf", 32'(overflow_err), 0);

        // Dual grant from reset
        cyc(); alloc_req = 2'b11; #3;
        chk("dual_ok", 32'(alloc_ok), 1);
        chk("dual_preg0", 32'(alloc_preg[0]), 32);
        chk("dual_preg1", 32'(alloc_preg[1]), 33);
        cyc(); alloc_req = 2'b00; #3;
        chk("dual_fc", 32'(free_count), 30);

        // Drain to empty; over-request is all-or-nothing
        do_reset();
        repeat (31) begin cyc(); alloc_req = 2'b01; end
        cyc(); alloc_req = 2'b11; #3;
        chk("short_ok", 32'(alloc_ok), 0);
        chk("short_fc", 32'(free_count), 1);
        cyc(); alloc_req = 2'b01; #3;
        chk("last_ok", 32'(alloc_ok), 1);
        chk("last_preg", 32'(alloc_preg[0]), 63);
        chk("last_fc", 32'(free_count), 1);
        cyc(); alloc_req = 2'b00; #3;
        chk("drained_empty", 32'(empty), 1);
        chk("drained_fc", 32'(free_count), 0);

        // Release into empty list is not bypassed to a same-cycle request
        cyc(); rel_en = 2'b11; rel_preg[0] = 6'd5; rel_preg[1] = 6'd9; alloc_req = 2'b01; #3;
        chk("nobypass_ok", 32'(alloc_ok), 0);
        cyc(); rel_en = 2'b00; alloc_req = 2'b01; #3;
        chk("reuse5_ok", 32'(alloc_ok), 1);
        chk("reuse5", 32'(alloc_preg[0]), 5);
        cyc(); alloc_req = 2'b01; #3;
        chk("reuse9", 32'(alloc_preg[0]), 9);
        cyc(); alloc_req = 2'b00; #3;
        chk("reuse_empty", 32'(empty), 1);

        // Checkpoint and recovery
        do_reset();
        cyc(); alloc_req = 2'b11;
        cyc(); alloc_req = 2'b11;
        cyc(); alloc_req = 2'b00; ckpt_take = 1'b1; ckpt_id = 3'd3; #3;
        chk("ck_fc28", 32'(free_count), 28);
        cyc(); ckpt_take = 1'b0; alloc_req = 2'b11; #3;
        chk("ck_preg36", 32'(alloc_preg[0]), 36);
        chk("ck_preg37", 32'(alloc_preg[1]), 37);
        cyc(); alloc_req = 2'b11; ckpt_take = 1'b1; ckpt_id = 3'd2;
        cyc(); alloc_req = 2'b11; ckpt_take = 1'b0;
        cyc(); alloc_req = 2'b01; rec_en = 1'b1; rec_ckpt_id = 3'd3; ckpt_take = 1'b1; ckpt_id = 3'd5; #3;
        chk("rec_ok", 32'(alloc_ok), 0);
        chk("rec_fc_before", 32'(free_count), 22);
        cyc(); rec_en = 1'b0; ckpt_take = 1'b0; alloc_req = 2'b01; #3;
        chk("rec_fc28", 32'(free_count), 28);
        chk("rec_preg36", 32'(alloc_preg[0]), 36);
        cyc(); alloc_req = 2'b00; rec_en = 1'b1; rec_ckpt_id = 3'd2; #3;
        chk("rec2_fc_before", 32'(free_count), 27);
        cyc(); rec_en = 1'b0; alloc_req = 2'b01; #3;
        chk("rec2_fc", 32'(free_count), 24);
        chk("rec2_preg40", 32'(alloc_preg[0]), 40);
        cyc(); alloc_req = 2'b00; rec_en = 1'b1; rec_ckpt_id = 3'd5;
        cyc(); rec_en = 1'b0; #3;
        chk("rec5_unwritten", 32'(free_count), 32);

        // Overflow is sticky until reset
        do_reset();
        cyc(); rel_en = 2'b01; rel_preg[0] = 6'd0; #3;
        chk("ovf_pre", 32'(overflow_err), 0);
        cyc(); rel_en = 2'b00; #3;
        chk("ovf_set", 32'(overflow_err), 1);
        chk("ovf_fc", 32'(free_count), 33);
        repeat (5) cyc();
        #3;
        chk("ovf_held", 32'(overflow_err), 1);
        cyc(); alloc_req = 2'b11; rst = 1'b1;
        cyc(); idle(); rst = 1'b0; #3;
        chk("ovf_cleared", 32'(overflow_err), 0);
        chk("midreset_fc", 32'(free_count), 32);

        // Random alloc/release of in-flight registers only
        do_reset();
        for (int c = 0; c < 200; c++) begin
            cyc();
            idle();
            alloc_req = 2'($urandom_range(0, 3));
            r = 2'($urandom_range(0, 3));
            for (int s = 0; s < 2; s++) begin
                if (r[s] && busy.size() > 0) begin
                    rel_en[s]   = 1'b1;
                    rel_preg[s] = 6'(busy.pop_front());
                end
            end
        end
        cyc(); idle(); #3;
        chk("rand_ovf", 32'(overflow_err), 0);
        chk("rand_fc", 32'(free_count), 32'(32 - busy.size()));
        for (int i = 0; i < 64; i++) bits[i] = 0;
        foreach (busy[i]) bits[busy[i]]++;
        for (int p = m_head; p < m_tail; p++) bits[m_mem[p % 64]]++;
        bad = 0;
        for (int i = 0; i < 64; i++) if (bits[i] != ((i >= 32) ? 1 : 0)) bad++;
        chk("rand_conserved", 32'(bad), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter P_REGISTERS, 64, physical register count; power of two.
REQ-002 Parameter L_REGISTERS, 32, architectural register count; less than P_REGISTERS.
REQ-003 Parameter INSTR_COUNT, 2, rename/commit slots per cycle.
REQ-004 Parameter CKPT_NUM, 8, checkpoint slots; power of two.
REQ-005 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Port alloc_req, input, [INSTR_COUNT], per-slot physical register request from rename.
REQ-008 Port alloc_preg, output, [INSTR_COUNT][$clog2(P_REGISTERS)], granted register per requesting slot.
REQ-009 Port alloc_ok, output, 1, all requested slots granted this cycle.
REQ-010 Port rel_en, input, [INSTR_COUNT], per-slot release of an old physical register from commit.
REQ-011 Port rel_preg, input, [INSTR_COUNT][$clog2(P_REGISTERS)], register being released.
REQ-012 Port ckpt_take, input, 1, snapshot head pointer.
REQ-013 Port ckpt_id, input, [$clog2(CKPT_NUM)], snapshot slot written.
REQ-014 Port rec_en, input, 1, restore head from a snapshot.
REQ-015 Port rec_ckpt_id, input, [$clog2(CKPT_NUM)], snapshot slot read.
REQ-016 Port free_count, output, [$clog2(P_REGISTERS)+1], registered count of free entries.
REQ-017 Port empty, output, 1, free_count == 0.
REQ-018 Port overflow_err, output, 1, sticky; release would exceed capacity.

Function
REQ-019 Storage: circular buffer of P_REGISTERS entries; head/tail pointers of $clog2(P_REGISTERS)+1 bits with the MSB as wrap bit; free_count = tail - head.
REQ-020 Allocation: n = popcount(alloc_req); if n <= free_count and !rec_en, alloc_ok=1, set slots receive entries head, head+1, ... in ascending slot order, head += n at the edge.
REQ-021 If n > free_count, alloc_ok=0, head unchanged, no entry consumed (all-or-nothing).
REQ-022 alloc_ok=1 when n==0; alloc_preg of unrequested slots is don't-care.
REQ-023 alloc_preg and alloc_ok are combinational from head, buffer and alloc_req (zero-cycle latency).
REQ-024 Release: set rel_en slots are written at tail, tail+1, ... in ascending slot order; tail += popcount(rel_en) at the edge.
REQ-025 Same-cycle alloc and release: allocation checks free_count before this cycle's releases; no bypass of released registers.
REQ-026 Overflow: if free_count + popcount(rel_en) exceeds P_REGISTERS - L_REGISTERS, overflow_err sets and stays set until reset; tail still advances.
REQ-027 Checkpoint: on ckpt_take, table[ckpt_id] <= next head, i.e. including this cycle's granted allocations.
REQ-028 Recovery: on rec_en, head <= table[rec_ckpt_id]; allocation suppressed (alloc_ok=0 if n>0); releases in that cycle still processed.
REQ-029 ckpt_take and rec_en together: rec_en wins; snapshot not written.
REQ-030 Pointer arithmetic wraps modulo 2*P_REGISTERS; entry index uses the low $clog2(P_REGISTERS) bits.

Reset
REQ-031 On rst: entries 0..P_REGISTERS-L_REGISTERS-1 hold L_REGISTERS..P_REGISTERS-1 ascending; head=0; tail=P_REGISTERS-L_REGISTERS.
REQ-032 Reset outputs: free_count=P_REGISTERS-L_REGISTERS, empty=0, overflow_err=0; checkpoint table entries all 0.
REQ-033 Reset mid-operation aborts any grant or release in that cycle; no partial pointer update survives.

Structure
REQ-034 P_REGISTERS, L_REGISTERS, INSTR_COUNT and a free-list pointer typedef belong in RR_pkg; CKPT_NUM is local.
REQ-035 Checkpoint table is sub-module fl_ckpt_table: CKPT_NUM x pointer-width registers, one write port, one async read port, async active-high reset.

Verification
REQ-036 Reset, then alloc_req=2'b11 -> alloc_ok=1, alloc_preg={33,32}, free_count=30 next cycle.
REQ-037 Allocate 31 singly, then alloc_req=2'b11 -> alloc_ok=0, head unchanged; alloc_req=2'b01 -> grants 63, empty=1 next cycle.
REQ-038 From empty, release 5 and 9 in one cycle with alloc_req=2'b01 -> alloc_ok=0 that cycle; next cycle grants 5, then 9.
REQ-039 Take checkpoint 3 after 4 allocations, allocate 6 more, rec_en with rec_ckpt_id=3 -> free_count back to 28, next grant is 36.
REQ-040 Run 200 cycles of random alloc/release with in-range reuse -> pointers wrap, no lost or duplicated register, overflow_err=0.
REQ-041 At free_count=32, release 1 register -> overflow_err=1 and held through later idle cycles until rst.
